// File: rtl/smj_hand_loader.sv
// Serial-to-parallel loader: collects five 6-bit tiles into a registered hand for the SMJ evaluator.
// Optional tile-code checking is enabled by defining SMJ_TILE_CHECK_EN.
module smj_hand_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] in_tile,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] hand_n0,
  output logic [5:0] hand_n1,
  output logic [5:0] hand_n2,
  output logic [5:0] hand_n3,
  output logic [5:0] hand_n4,
  output logic       out_err
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] hand_q [0:4];
  logic       accept_s;

  // Next-state logic: INIT always falls through to FILL, fifth accepted tile closes the hand.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      S_INIT: begin
        state_d = S_FILL;
      end
      S_FILL: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (cnt_q == 3'd4) begin
            cnt_d   = 3'd0;
            state_d = S_FULL;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          state_d = S_FILL;
        end else begin
          state_d = S_FULL;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, fill counter and hand slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 5; i++) begin
        hand_q[i] <= 6'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        hand_q[cnt_q] <= in_tile;
      end
    end
  end

  assign in_ready  = (state_q == S_FILL);
  assign out_valid = (state_q == S_FULL);
  assign hand_n0   = hand_q[0];
  assign hand_n1   = hand_q[1];
  assign hand_n2   = hand_q[2];
  assign hand_n3   = hand_q[3];
  assign hand_n4   = hand_q[4];

`ifdef SMJ_TILE_CHECK_EN
  logic err_q, err_d;

  // Honors carry values 0..6, suited tiles 0..8.
  function automatic logic tile_illegal(input logic [5:0] tile);
    if (tile[5:4] == 2'b00) begin
      return (tile[3:0] > 4'd6);
    end else begin
      return (tile[3:0] > 4'd8);
    end
  endfunction

  // Sticky per-hand error flag, cleared when the hand is consumed.
  always_comb begin
    err_d = err_q;
    if ((state_q == S_FULL) && out_ready) begin
      err_d = 1'b0;
    end else if (accept_s && tile_illegal(in_tile)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = (state_q == S_FULL) && err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule
